// File: rtl/fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl
//   Control path for an 8-entry FIFO. It tracks the read pointer (head), the
//   write pointer (tail) and the occupancy (data_count). It produces the
//   memory strobes and the handshake flags for an external 8x memory.
//
//   The controller is a registered-state machine. The state register holds
//   the operation accepted at the previous edge. The pointer and count
//   registers apply that operation on the following edge. Requests are
//   therefore visible on state/strobes one cycle before they show up in
//   head/tail/data_count.
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   synchronous active-high reset
//   wr_en       in   write request for this cycle
//   rd_en       in   read request for this cycle
//   state       out  [2:0] registered FSM state (encoding in table below)
//   head        out  [2:0] read pointer / memory read address
//   tail        out  [2:0] write pointer / memory write address
//   data_count  out  [3:0] occupancy, 0..8
//   we, re      out  memory write / read strobes
//   full, empty out  occupancy flags
//   wr_ack, wr_err, rd_ack, rd_err  out  per-request handshake flags
//
// State table
//   state     | code | meaning
//   INIT      | 000  | after reset; next edge clears pointers and count
//   NO_OP     | 001  | idle or simultaneous request; hold everything
//   WRITE     | 010  | write accepted; next edge advances tail, count+1
//   READ      | 011  | read accepted; next edge advances head, count-1
//   WR_ERROR  | 100  | write refused (full); count pinned at 8
//   RD_ERROR  | 101  | read refused (empty); count pinned at 0
// ---------------------------------------------------------------------------
module fifo_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic [2:0] state,
  output logic [2:0] head,
  output logic [2:0] tail,
  output logic [3:0] data_count,
  output logic       we,
  output logic       re,
  output logic       full,
  output logic       empty,
  output logic       wr_ack,
  output logic       wr_err,
  output logic       rd_ack,
  output logic       rd_err
);

  typedef enum logic [2:0] {
    ST_INIT     = 3'b000,
    ST_NO_OP    = 3'b001,
    ST_WRITE    = 3'b010,
    ST_READ     = 3'b011,
    ST_WR_ERROR = 3'b100,
    ST_RD_ERROR = 3'b101
  } state_e;

  localparam logic [3:0] COUNT_MAX = 4'd8;

  state_e     state_q, state_d;
  logic [2:0] head_q, head_d;
  logic [2:0] tail_q, tail_d;
  logic [3:0] count_q, count_d;
  logic [3:0] eff_count;
  logic       state_legal;

  // Pointer/count update implied by the operation currently held in the
  // state register. Pointers are 3 bits, so 7+1 wraps to 0 for free.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    state_legal = 1'b1;
    case (state_q)
      ST_INIT: begin
        head_d  = 3'd0;
        tail_d  = 3'd0;
        count_d = 4'd0;
      end
      ST_NO_OP: begin
      end
      ST_WRITE: begin
        tail_d  = tail_q + 3'd1;
        count_d = count_q + 4'd1;
      end
      ST_READ: begin
        head_d  = head_q + 3'd1;
        count_d = count_q - 4'd1;
      end
      ST_WR_ERROR: begin
        count_d = COUNT_MAX;
      end
      ST_RD_ERROR: begin
        count_d = 4'd0;
      end
      default: begin
        state_legal = 1'b0;
      end
    endcase
  end

  // The accept decision must see the count the pointer update is about to
  // produce. Otherwise a write issued at count 7 directly after another
  // write would be accepted and overflow.
  assign eff_count = count_d;

  always_comb begin
    state_d = ST_NO_OP;
    if (state_legal) begin
      if (wr_en && !rd_en) begin
        state_d = (eff_count < COUNT_MAX) ? ST_WRITE : ST_WR_ERROR;
      end else if (rd_en && !wr_en) begin
        state_d = (eff_count != 4'd0) ? ST_READ : ST_RD_ERROR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      head_q  <= 3'd0;
      tail_q  <= 3'd0;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign state      = state_q;
  assign head       = head_q;
  assign tail       = tail_q;
  assign data_count = count_q;

  assign we     = (state_q == ST_WRITE);
  assign re     = (state_q == ST_READ);
  assign wr_ack = (state_q == ST_WRITE);
  assign rd_ack = (state_q == ST_READ);
  assign wr_err = (state_q == ST_WR_ERROR);
  assign rd_err = (state_q == ST_RD_ERROR);
  assign full   = (count_q == COUNT_MAX);
  assign empty  = (count_q == 4'd0);

endmodule

// File: tb/tb_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_ctrl
//   Directed-vector bench for fifo_ctrl. Each vector carries hand-computed
//   state/head/tail/data_count for just after the edge that samples it. The
//   flag outputs are derived from those expected values by their defining
//   rules. A monitor process pops each expectation and checks the DUT one
//   time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_fifo_ctrl;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic       rd_en;
  logic [2:0] state;
  logic [2:0] head;
  logic [2:0] tail;
  logic [3:0] data_count;
  logic       we, re, full, empty, wr_ack, wr_err, rd_ack, rd_err;

  fifo_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .state      (state),
    .head       (head),
    .tail       (tail),
    .data_count (data_count),
    .we         (we),
    .re         (re),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
  );

  localparam logic [2:0] S_INIT = 3'b000, S_NOP = 3'b001, S_WR = 3'b010,
                         S_RD   = 3'b011, S_WER = 3'b100, S_RER = 3'b101;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [2:0] hd;
    logic [2:0] tl;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packed layout: {state, head, tail, count, we, re, full, empty,
  //                 wr_ack, wr_err, rd_ack, rd_err}
  function automatic logic [20:0] model_pack(input exp_t e);
    logic we_m, re_m, full_m, empty_m, wa_m, we_e, ra_m, re_e;
    we_m    = (e.st == S_WR);
    re_m    = (e.st == S_RD);
    full_m  = (e.cnt == 4'd8);
    empty_m = (e.cnt == 4'd0);
    wa_m    = (e.st == S_WR);
    we_e    = (e.st == S_WER);
    ra_m    = (e.st == S_RD);
    re_e    = (e.st == S_RER);
    return {e.st, e.hd, e.tl, e.cnt, we_m, re_m, full_m, empty_m,
            wa_m, we_e, ra_m, re_e};
  endfunction

  task automatic apply(input string nm, input logic r, input logic w,
                       input logic d, input logic [2:0] st,
                       input logic [2:0] hd, input logic [2:0] tl,
                       input logic [3:0] cnt);
    exp_t e;
    @(negedge clk);
    reset = r;
    wr_en = w;
    rd_en = d;
    e.name = nm;
    e.st   = st;
    e.hd   = hd;
    e.tl   = tl;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: the DUT presents a fresh output word after every edge.
  initial begin
    exp_t        e;
    logic [20:0] act, req;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {state, head, tail, data_count, we, re, full, empty,
               wr_ack, wr_err, rd_ack, rd_err};
        req = model_pack(e);
        n_vec++;
        if (act !== req) begin
          n_err++;
          $display("FAIL %s: actual st=%0d h=%0d t=%0d c=%0d flags=%b, required st=%0d h=%0d t=%0d c=%0d flags=%b",
                   e.name, act[20:18], act[17:15], act[14:12], act[11:8],
                   act[7:0], req[20:18], req[17:15], req[14:12], req[11:8],
                   req[7:0]);
        end
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;

    //    name          rst wr rd  state  head tail cnt
    apply("reset",      1, 0, 0, S_INIT, 0, 0, 4'd0);
    apply("idle0",      0, 0, 0, S_NOP,  0, 0, 4'd0);
    apply("idle1",      0, 0, 0, S_NOP,  0, 0, 4'd0);
    apply("idle2",      0, 0, 0, S_NOP,  0, 0, 4'd0);
    // Eight back-to-back writes from empty.
    apply("wr1",        0, 1, 0, S_WR,   0, 0, 4'd0);
    apply("wr2",        0, 1, 0, S_WR,   0, 1, 4'd1);
    apply("wr3",        0, 1, 0, S_WR,   0, 2, 4'd2);
    apply("wr4",        0, 1, 0, S_WR,   0, 3, 4'd3);
    apply("wr5",        0, 1, 0, S_WR,   0, 4, 4'd4);
    apply("wr6",        0, 1, 0, S_WR,   0, 5, 4'd5);
    apply("wr7",        0, 1, 0, S_WR,   0, 6, 4'd6);
    apply("wr8",        0, 1, 0, S_WR,   0, 7, 4'd7);
    // Ninth write sees eff=8: refused, tail wraps to 0, count 8.
    apply("wr_ovf",     0, 1, 0, S_WER,  0, 0, 4'd8);
    apply("full_idle",  0, 0, 0, S_NOP,  0, 0, 4'd8);
    apply("wr_full",    0, 1, 0, S_WER,  0, 0, 4'd8);
    apply("full_idle2", 0, 0, 0, S_NOP,  0, 0, 4'd8);
    // Five reads down to count 3.
    apply("rd1",        0, 0, 1, S_RD,   0, 0, 4'd8);
    apply("rd2",        0, 0, 1, S_RD,   1, 0, 4'd7);
    apply("rd3",        0, 0, 1, S_RD,   2, 0, 4'd6);
    apply("rd4",        0, 0, 1, S_RD,   3, 0, 4'd5);
    apply("rd5",        0, 0, 1, S_RD,   4, 0, 4'd4);
    apply("c3_idle",    0, 0, 0, S_NOP,  5, 0, 4'd3);
    // Simultaneous requests: nothing moves.
    apply("both1",      0, 1, 1, S_NOP,  5, 0, 4'd3);
    apply("both2",      0, 1, 1, S_NOP,  5, 0, 4'd3);
    // Drain; the read issued at eff=0 is refused, head wraps 7->0.
    apply("rd6",        0, 0, 1, S_RD,   5, 0, 4'd3);
    apply("rd7",        0, 0, 1, S_RD,   6, 0, 4'd2);
    apply("rd8",        0, 0, 1, S_RD,   7, 0, 4'd1);
    apply("rd_unf",     0, 0, 1, S_RER,  0, 0, 4'd0);
    apply("rd_empty",   0, 0, 1, S_RER,  0, 0, 4'd0);
    apply("empty_idle", 0, 0, 0, S_NOP,  0, 0, 4'd0);
    // Build to count 5 in WRITE, then reset mid-write.
    apply("wr_a",       0, 1, 0, S_WR,   0, 0, 4'd0);
    apply("wr_b",       0, 1, 0, S_WR,   0, 1, 4'd1);
    apply("wr_c",       0, 1, 0, S_WR,   0, 2, 4'd2);
    apply("wr_d",       0, 1, 0, S_WR,   0, 3, 4'd3);
    apply("wr_e",       0, 1, 0, S_WR,   0, 4, 4'd4);
    apply("wr_f",       0, 1, 0, S_WR,   0, 5, 4'd5);
    apply("rst_mid",    1, 1, 0, S_INIT, 0, 0, 4'd0);
    // First edge after reset: INIT clears, write accepted with eff=0.
    apply("post_rst",   0, 1, 0, S_WR,   0, 0, 4'd0);
    apply("post_idle",  0, 0, 0, S_NOP,  0, 1, 4'd1);
    apply("both3",      0, 1, 1, S_NOP,  0, 1, 4'd1);
    apply("rd_last",    0, 0, 1, S_RD,   0, 1, 4'd1);
    apply("final",      0, 0, 0, S_NOP,  1, 1, 4'd0);

    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: actual %0d expectations pending, required 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
